watchman_axil_regs: RTL and testbench
=====================================

// Module: watchman_axil_regs
// PURPOSE
//  AXI4-Lite slave register bank that receives the single-beat AXI4-Lite traffic issued by the master VIP/PS.
//  Decodes word addresses into NUM_REGS 32-bit read/write control registers.
//  Drives the register contents and one-cycle write strobes into WATCHMAN fabric logic.
//  One outstanding write and one outstanding read at a time; write and read channels run independently.
// PARAMETERS
//  DATA_W    32  AXI data width; only 32 is supported.
//  ADDR_W    4   AXI byte-address width; bits [1:0] are ignored.
//  NUM_REGS  4   number of registers, at offsets 0x0, 0x4, ..., 4*(NUM_REGS-1); range 1..2**(ADDR_W-2).
// PORTS
//  ACLK      in   1                  single clock, rising-edge.
//  ARESETN   in   1                  asynchronous, active-low reset.
//  AWADDR    in   ADDR_W             write address.
//  AWPROT    in   3                  accepted, ignored.
//  AWVALID   in   1                  write-address valid.
//  AWREADY   out  1                  write-address ready.
//  WDATA     in   DATA_W             write data.
//  WSTRB     in   DATA_W/8           byte enables.
//  WVALID    in   1                  write-data valid.
//  WREADY    out  1                  write-data ready.
//  BRESP     out  2                  write response: 00 OKAY, 10 SLVERR.
//  BVALID    out  1                  write response valid.
//  BREADY    in   1                  write response ready.
//  ARADDR    in   ADDR_W             read address.
//  ARPROT    in   3                  accepted, ignored.
//  ARVALID   in   1                  read-address valid.
//  ARREADY   out  1                  read-address ready.
//  RDATA     out  DATA_W             read data.
//  RRESP     out  2                  read response: 00 OKAY, 10 SLVERR.
//  RVALID    out  1                  read data valid.
//  RREADY    in   1                  read data ready.
//  regs_o    out  NUM_REGS*DATA_W    register contents; reg k is at [k*32 +: 32].
//  wr_stb_o  out  NUM_REGS           one-cycle pulse when reg k is written.
// BEHAVIOUR
//  Reset (ARESETN=0, asynchronous):
//   - all registers, RDATA, BRESP, RRESP = 0;
//   - BVALID, RVALID, wr_stb_o = 0;
//   - AW/W holding buffers empty.
//  Write channel:
//   - AW and W are captured independently, each into its own one-entry buffer.
//   - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
//   - AW and W may arrive in either order or in the same cycle.
//  Commit:
//   - Occurs on the first edge where both buffers are full (or are being filled this cycle) and BVALID=0.
//   - Reg[addr>>2] byte lanes with WSTRB=1 take WDATA; the other lanes are kept.
//   - At that same edge: BVALID<=1, wr_stb_o[k]<=1 for one cycle, both buffers are cleared.
//   - Back-to-back AW+W on a free bank: BVALID rises 1 cycle after the handshake.
//   - Index >= NUM_REGS: no register changes, no strobe, BRESP=10; otherwise BRESP=00.
//   - WSTRB=0: OKAY response; the strobe still pulses; data is unchanged.
//   - BVALID stays high until BREADY. AWREADY/WREADY are low while BVALID=1, so at most one write is in flight.
//  Read channel:
//   - ARREADY = !RVALID.
//   - On the AR handshake: RDATA <= reg[ARADDR>>2], RVALID <= 1, RRESP = 00.
//   - Out-of-range index: RDATA = 0, RRESP = 10.
//   - RDATA/RRESP are held stable while RVALID && !RREADY; RVALID clears on RREADY.
//   - Read latency: 1 cycle from the AR handshake.
//  Simultaneous events:
//   - Read and write commit to the same reg in the same cycle: the read returns the pre-write value.
//   - The write and read channels never stall each other.
//  Reset mid-transaction: any pending AW/W/B/R is dropped and the bus returns to idle. No partial write occurs.
//  regs_o is a direct register output, with no combinational path from AXI inputs. wr_stb_o is registered.
// STRUCTURE
//  Package watchman_axil_pkg holds:
//   - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
//   - the axil_resp_t typedef;
//   - the word_index function (addr >> 2).
//  No sub-module: the write buffering and the read path are always_ff blocks in this file.
// TESTING
//  1. Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read them back -> RDATA 1..4, all RESP=00, each wr_stb_o pulses once.
//  2. W presented 3 cycles before AW at 0x8 (data 0xA5A5A5A5) -> BVALID 1 cycle after AW, reg2=0xA5A5A5A5.
//  3. reg1=0x11223344; write 0xFFFFFFFF with WSTRB=4'b0101 -> reg1=0x11FF33FF.
//  4. Write to 0x10 with NUM_REGS=4 -> BRESP=10, regs unchanged. Read of 0x10 -> RDATA=0, RRESP=10.
//  5. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data stay stable; AWREADY/ARREADY stay low.
//  6. Deassert ARESETN with AW accepted but no W -> all outputs 0; a new full write afterwards completes normally.

Source files
------------

// File: rtl/watchman_axil_pkg.sv
// Shared AXI4-Lite response codes and address helpers
// for the WATCHMAN control register bank.
package watchman_axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/watchman_axil_regs.sv
// AXI4-Lite slave register bank feeding WATCHMAN fabric logic
// with register contents and registered write strobes.
module watchman_axil_regs
  import watchman_axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]      wr_stb_o
);

  localparam int NB = DATA_W / 8;

  logic                aw_full;
  logic                w_full;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [NB-1:0]       w_strb_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                bvalid_q;
  axil_resp_t          bresp_q;
  logic [NUM_REGS-1:0] wr_stb_q;
  logic                rvalid_q;
  axil_resp_t          rresp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NB-1:0]       wr_strb;
  logic [29:0]         wr_idx;
  logic                wr_ok;
  logic [29:0]         rd_idx;
  logic                rd_ok;
  logic [DATA_W-1:0]   rd_word;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  assign AWREADY = !aw_full && !bvalid_q;
  assign WREADY  = !w_full && !bvalid_q;
  assign ARREADY = !rvalid_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A buffer being filled this cycle counts as full for commit.
  assign wr_addr = aw_full ? aw_addr_q : AWADDR;
  assign wr_data = w_full ? w_data_q : WDATA;
  assign wr_strb = w_full ? w_strb_q : WSTRB;
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs) && !bvalid_q;

  assign wr_idx = word_index(32'(wr_addr));
  assign wr_ok  = wr_idx < 30'(NUM_REGS);
  assign rd_idx = word_index(32'(ARADDR));
  assign rd_ok  = rd_idx < 30'(NUM_REGS);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_idx == 30'(k))
        rd_word = regs_q[k];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++)
        regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        for (int b = 0; b < NB; b++)
          if (commit && wr_ok && wr_idx == 30'(k) && wr_strb[b])
            regs_q[k][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      wr_stb_q <= '0;
    end else begin
      wr_stb_q <= '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++)
          wr_stb_q[k] <= wr_ok && wr_idx == 30'(k);
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_ok ? rd_word : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign wr_stb_o = wr_stb_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_watchman_axil_regs.sv
// Directed scoreboard bench for watchman_axil_regs.
// Built with a 5-bit address so offset 0x10 is reachable.
module tb_watchman_axil_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [4:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] regs_o;
  logic [3:0]   wr_stb_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] m [4];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  always #5 clk = ~clk;

  watchman_axil_regs #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_REGS(4)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .AWADDR  (awaddr),
    .AWPROT  (awprot),
    .AWVALID (awvalid),
    .AWREADY (awready),
    .WDATA   (wdata),
    .WSTRB   (wstrb),
    .WVALID  (wvalid),
    .WREADY  (wready),
    .BRESP   (bresp),
    .BVALID  (bvalid),
    .BREADY  (bready),
    .ARADDR  (araddr),
    .ARPROT  (arprot),
    .ARVALID (arvalid),
    .ARREADY (arready),
    .RDATA   (rdata),
    .RRESP   (rresp),
    .RVALID  (rvalid),
    .RREADY  (rready),
    .regs_o  (regs_o),
    .wr_stb_o(wr_stb_o)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs();
    for (int k = 0; k < 4; k++)
      check($sformatf("regs_o[%0d]", k), 64'(regs_o[k*32 +: 32]), 64'(m[k]));
  endtask

  // Model update and scoreboard push for one write.
  task automatic expect_write(input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [3:0] stb);
    int idx;
    idx = int'(a >> 2);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m[idx][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
      stb = 4'(1 << idx);
    end else begin
      exp_b.push_back(2'b10);
      stb = 4'b0000;
    end
  endtask

  task automatic finish_b(input logic [3:0] stb, input int hold);
    int n;
    logic [1:0] r;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    check("b_valid", 64'(bvalid), 64'(1));
    r = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
    check("bresp", 64'(bresp), 64'(r));
    check("wr_stb", 64'(wr_stb_o), 64'(stb));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("b_hold", 64'(bvalid), 64'(1));
      check("b_hold_resp", 64'(bresp), 64'(r));
      check("aw_blocked", 64'(awready), 64'(0));
      check("w_blocked", 64'(wready), 64'(0));
      check("stb_once", 64'(wr_stb_o), 64'(0));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", 64'(bvalid), 64'(0));
    check("stb_clear", 64'(wr_stb_o), 64'(0));
    check_regs();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold);
    logic [3:0] stb;
    logic ah, wh;
    int n;
    expect_write(a, d, s, stb);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept", 64'(awvalid || wvalid), 64'(0));
    awvalid = 1'b0; wvalid = 1'b0;
    finish_b(stb, hold);
  endtask

  // W is accepted alone, AW follows gap cycles later.
  task automatic w_then_aw(input logic [4:0] a, input logic [31:0] d,
                           input int gap);
    logic [3:0] stb;
    expect_write(a, d, 4'hF, stb);
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    check("w_ready", 64'(wready), 64'(1));
    tick();
    wvalid = 1'b0;
    for (int i = 1; i < gap; i++) tick();
    check("w_only_no_b", 64'(bvalid), 64'(0));
    awaddr = a; awvalid = 1'b1;
    check("aw_ready", 64'(awready), 64'(1));
    tick();
    awvalid = 1'b0;
    check("b_latency", 64'(bvalid), 64'(1));
    finish_b(stb, 0);
  endtask

  task automatic do_read(input logic [4:0] a, input int hold);
    int idx, n;
    logic [33:0] e;
    logic ah;
    idx = int'(a >> 2);
    if (idx < 4) exp_r.push_back({2'b00, m[idx]});
    else         exp_r.push_back({2'b10, 32'h0});
    araddr = a; arvalid = 1'b1;
    n = 0; ah = 1'b0;
    while (!ah && n < 20) begin
      ah = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    check("ar_accept", 64'(ah), 64'(1));
    check("r_latency", 64'(rvalid), 64'(1));
    e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
    check("rdata", 64'(rdata), 64'(e[31:0]));
    check("rresp", 64'(rresp), 64'(e[33:32]));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("r_hold", 64'(rvalid), 64'(1));
      check("r_hold_data", 64'(rdata), 64'(e[31:0]));
      check("ar_blocked", 64'(arready), 64'(0));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_done", 64'(rvalid), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m[k] = '0;
    repeat (3) tick();
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_stb", 64'(wr_stb_o), 64'(0));
    check("rst_regs", 64'(|regs_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Basic writes then readback
    do_write(5'h00, 32'h1, 4'hF, 0);
    do_write(5'h04, 32'h2, 4'hF, 0);
    do_write(5'h08, 32'h3, 4'hF, 0);
    do_write(5'h0C, 32'h4, 4'hF, 0);
    for (int k = 0; k < 4; k++) do_read(5'(4 * k), 0);

    // W ahead of AW
    w_then_aw(5'h08, 32'hA5A5A5A5, 3);
    check("reg2_a5", 64'(regs_o[64 +: 32]), 64'h0000_0000_A5A5_A5A5);
    do_read(5'h08, 0);

    // Byte strobes
    do_write(5'h04, 32'h11223344, 4'hF, 0);
    do_write(5'h04, 32'hFFFFFFFF, 4'b0101, 0);
    check("reg1_merge", 64'(regs_o[32 +: 32]), 64'h0000_0000_11FF_33FF);
    do_write(5'h04, 32'h0BADF00D, 4'b0000, 0);
    do_read(5'h04, 0);

    // Out of range
    do_write(5'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(5'h10, 0);

    // Backpressure on B and R
    do_write(5'h00, 32'hCAFE0001, 4'hF, 5);
    do_read(5'h00, 5);

    // Reset with AW accepted but W missing
    awaddr = 5'h0C; awvalid = 1'b1;
    check("aw_pre_rst", 64'(awready), 64'(1));
    tick();
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) m[k] = '0;
    check("mid_rst_bvalid", 64'(bvalid), 64'(0));
    check("mid_rst_rvalid", 64'(rvalid), 64'(0));
    check("mid_rst_rdata", 64'(rdata), 64'(0));
    check("mid_rst_stb", 64'(wr_stb_o), 64'(0));
    check_regs();
    tick();
    rst_n = 1'b1;
    tick();
    w_then_aw(5'h04, 32'h5EED0004, 2);
    do_read(5'h04, 0);
    do_read(5'h0C, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
